// File: rtl/ysyx_23060240_idu_stage.sv
// RV32I/RV32E decode stage with a DEPTH-entry FIFO of decoded bundles between IFU and EXU.
// Define YSYX_23060240_IDU_RV32M_EN to also decode the RV32M multiply/divide group.
module ysyx_23060240_idu_stage #(
  parameter int RF_ADDR_W = 5,
  parameter int DEPTH     = 2,
  parameter int PC_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [PC_W-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [RF_ADDR_W-1:0] rd,
  output logic [RF_ADDR_W-1:0] rs1,
  output logic [RF_ADDR_W-1:0] rs2,
  output logic [31:0]          imm,
  output logic                 alu_a_sel,
  output logic                 alu_b_sel,
  output logic                 w_en,
  output logic                 jump,
  output logic [1:0]           w_sel,
  output logic [2:0]           branch_type,
  output logic [3:0]           alu_func,
  output logic [2:0]           mem_rd_ctrl,
  output logic [1:0]           mem_wr_ctrl,
  output logic                 is_jal,
  output logic                 is_jalr,
  output logic                 illegal,
  output logic                 ebreak,
  output logic                 is_mdu,
  output logic [2:0]           mdu_op
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic [31:0]          imm;
    logic                 alu_a_sel;
    logic                 alu_b_sel;
    logic                 w_en;
    logic                 jump;
    logic [1:0]           w_sel;
    logic [2:0]           branch_type;
    logic [3:0]           alu_func;
    logic [2:0]           mem_rd_ctrl;
    logic [1:0]           mem_wr_ctrl;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 illegal;
    logic                 ebreak;
    logic                 is_mdu;
    logic [2:0]           mdu_op;
  } bundle_t;

  // A register field fits the file when no bit above RF_ADDR_W-1 is set.
  function automatic logic idx_fits(input logic [4:0] f);
    return (f >> RF_ADDR_W) == 5'd0;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  bundle_t     dec;
  logic        legal, use_rd, use_rs1, use_rs2, bad_idx;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign rd_f   = in_inst[11:7];
  assign rs1_f  = in_inst[19:15];
  assign rs2_f  = in_inst[24:20];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'h000};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Combinational decode; anything not recognised collapses to an illegal bundle carrying only pc.
  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    bad_idx = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        legal         = 1'b1;
        use_rd        = 1'b1;
        dec.imm       = imm_u;
        dec.w_en      = 1'b1;
        dec.w_sel     = 2'b10;
        dec.alu_b_sel = 1'b1;
        dec.alu_func  = (opcode == OP_LUI) ? 4'b1110 : 4'b0000;
      end
      OP_JAL: begin
        legal         = 1'b1;
        use_rd        = 1'b1;
        dec.imm       = imm_j;
        dec.w_en      = 1'b1;
        dec.w_sel     = 2'b01;
        dec.alu_b_sel = 1'b1;
        dec.jump      = 1'b1;
        dec.is_jal    = 1'b1;
      end
      OP_JALR: begin
        legal         = (funct3 == 3'b000);
        use_rd        = 1'b1;
        use_rs1       = 1'b1;
        dec.imm       = imm_i;
        dec.w_en      = 1'b1;
        dec.w_sel     = 2'b01;
        dec.alu_a_sel = 1'b1;
        dec.alu_b_sel = 1'b1;
        dec.jump      = 1'b1;
        dec.is_jalr   = 1'b1;
      end
      OP_BRANCH: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.imm       = imm_b;
        dec.alu_b_sel = 1'b1;
        case (funct3)
          3'b000:  dec.branch_type = 3'b001;
          3'b001:  dec.branch_type = 3'b010;
          3'b100:  dec.branch_type = 3'b011;
          3'b101:  dec.branch_type = 3'b100;
          3'b110:  dec.branch_type = 3'b101;
          3'b111:  dec.branch_type = 3'b110;
          default: dec.branch_type = 3'b000;
        endcase
        legal = (dec.branch_type != 3'b000);
      end
      OP_LOAD: begin
        use_rd        = 1'b1;
        use_rs1       = 1'b1;
        dec.imm       = imm_i;
        dec.w_en      = 1'b1;
        dec.w_sel     = 2'b11;
        dec.alu_a_sel = 1'b1;
        dec.alu_b_sel = 1'b1;
        case (funct3)
          3'b000:  dec.mem_rd_ctrl = 3'b001;
          3'b100:  dec.mem_rd_ctrl = 3'b010;
          3'b001:  dec.mem_rd_ctrl = 3'b011;
          3'b101:  dec.mem_rd_ctrl = 3'b100;
          3'b010:  dec.mem_rd_ctrl = 3'b101;
          default: dec.mem_rd_ctrl = 3'b000;
        endcase
        legal = (dec.mem_rd_ctrl != 3'b000);
      end
      OP_STORE: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.imm       = imm_s;
        dec.alu_a_sel = 1'b1;
        dec.alu_b_sel = 1'b1;
        case (funct3)
          3'b000:  dec.mem_wr_ctrl = 2'b01;
          3'b001:  dec.mem_wr_ctrl = 2'b10;
          3'b010:  dec.mem_wr_ctrl = 2'b11;
          default: dec.mem_wr_ctrl = 2'b00;
        endcase
        legal = (dec.mem_wr_ctrl != 2'b00);
      end
      OP_IMM: begin
        use_rd        = 1'b1;
        use_rs1       = 1'b1;
        dec.imm       = imm_i;
        dec.w_en      = 1'b1;
        dec.w_sel     = 2'b10;
        dec.alu_a_sel = 1'b1;
        dec.alu_b_sel = 1'b1;
        case (funct3)
          3'b001: begin
            legal        = (funct7 == 7'h00);
            dec.alu_func = 4'b0001;
          end
          3'b101: begin
            legal        = (funct7 == 7'h00) || (funct7 == 7'h20);
            dec.alu_func = {funct7[5], 3'b101};
          end
          default: begin
            legal        = 1'b1;
            dec.alu_func = {1'b0, funct3};
          end
        endcase
      end
      OP_OP: begin
        use_rd        = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.w_en      = 1'b1;
        dec.w_sel     = 2'b10;
        dec.alu_a_sel = 1'b1;
        if (funct7 == 7'h00) begin
          legal        = 1'b1;
          dec.alu_func = {1'b0, funct3};
        end else if ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          legal        = 1'b1;
          dec.alu_func = {1'b1, funct3};
`ifdef YSYX_23060240_IDU_RV32M_EN
        end else if (funct7 == 7'h01) begin
          legal        = 1'b1;
          dec.is_mdu   = 1'b1;
          dec.mdu_op   = funct3;
          dec.alu_func = 4'b0000;
`endif
        end else begin
          legal = 1'b0;
        end
      end
      OP_FENCE: begin
        legal = (funct3 == 3'b000);
      end
      OP_SYSTEM: begin
        legal      = (in_inst == 32'h0010_0073);
        dec.ebreak = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    bad_idx = (use_rd & ~idx_fits(rd_f)) | (use_rs1 & ~idx_fits(rs1_f)) | (use_rs2 & ~idx_fits(rs2_f));
    if (legal && !bad_idx) begin
      dec.rd  = use_rd  ? rd_f[RF_ADDR_W-1:0]  : '0;
      dec.rs1 = use_rs1 ? rs1_f[RF_ADDR_W-1:0] : '0;
      dec.rs2 = use_rs2 ? rs2_f[RF_ADDR_W-1:0] : '0;
    end else begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.pc = in_pc;
  end

  bundle_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  bundle_t          head;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Bundle storage; flush suppresses the write so a flushed input is never captured.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Circular-buffer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end else begin
        count <= count;
      end
    end
  end

  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_pc      = head.pc;
  assign rd          = head.rd;
  assign rs1         = head.rs1;
  assign rs2         = head.rs2;
  assign imm         = head.imm;
  assign alu_a_sel   = head.alu_a_sel;
  assign alu_b_sel   = head.alu_b_sel;
  assign w_en        = head.w_en;
  assign jump        = head.jump;
  assign w_sel       = head.w_sel;
  assign branch_type = head.branch_type;
  assign alu_func    = head.alu_func;
  assign mem_rd_ctrl = head.mem_rd_ctrl;
  assign mem_wr_ctrl = head.mem_wr_ctrl;
  assign is_jal      = head.is_jal;
  assign is_jalr     = head.is_jalr;
  assign illegal     = head.illegal;
  assign ebreak      = head.ebreak;
  assign is_mdu      = head.is_mdu;
  assign mdu_op      = head.mdu_op;

endmodule

// File: tb/tb_ysyx_23060240_idu_stage.sv
// Bench: an RV32I (rf5) and an RV32E (rf4) instance share one stimulus stream and are
// compared every cycle against an instruction-level FIFO model, plus directed literal checks.
module tb_ysyx_23060240_idu_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready_a, out_valid_a, in_ready_e, out_valid_e;
  logic [31:0] out_pc_a, imm_a, out_pc_e, imm_e;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [3:0]  rd_e, rs1_e, rs2_e;
  logic        a_sel_a, b_sel_a, w_en_a, jump_a, jal_a, jalr_a, ill_a, ebk_a, mdu_a;
  logic        a_sel_e, b_sel_e, w_en_e, jump_e, jal_e, jalr_e, ill_e, ebk_e, mdu_e;
  logic [1:0]  w_sel_a, mwr_a, w_sel_e, mwr_e;
  logic [2:0]  br_a, mrd_a, mop_a, br_e, mrd_e, mop_e;
  logic [3:0]  func_a, func_e;

  ysyx_23060240_idu_stage #(.RF_ADDR_W(5), .DEPTH(DEPTH), .PC_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a), .imm(imm_a),
    .alu_a_sel(a_sel_a), .alu_b_sel(b_sel_a), .w_en(w_en_a), .jump(jump_a), .w_sel(w_sel_a),
    .branch_type(br_a), .alu_func(func_a), .mem_rd_ctrl(mrd_a), .mem_wr_ctrl(mwr_a),
    .is_jal(jal_a), .is_jalr(jalr_a), .illegal(ill_a), .ebreak(ebk_a), .is_mdu(mdu_a), .mdu_op(mop_a));

  ysyx_23060240_idu_stage #(.RF_ADDR_W(4), .DEPTH(DEPTH), .PC_W(32)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_e),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_e), .out_ready(out_ready),
    .out_pc(out_pc_e), .rd(rd_e), .rs1(rs1_e), .rs2(rs2_e), .imm(imm_e),
    .alu_a_sel(a_sel_e), .alu_b_sel(b_sel_e), .w_en(w_en_e), .jump(jump_e), .w_sel(w_sel_e),
    .branch_type(br_e), .alu_func(func_e), .mem_rd_ctrl(mrd_e), .mem_wr_ctrl(mwr_e),
    .is_jal(jal_e), .is_jalr(jalr_e), .illegal(ill_e), .ebreak(ebk_e), .is_mdu(mdu_e), .mdu_op(mop_e));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        a_sel, b_sel, w_en, jump;
    logic [1:0]  w_sel;
    logic [2:0]  br;
    logic [3:0]  func;
    logic [2:0]  mrd;
    logic [1:0]  mwr;
    logic        jal, jalr, ill, ebk, mdu;
    logic [2:0]  mop;
  } bnd_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  bnd_t got_a, got_e;
  assign got_a = {out_pc_a, rd_a, rs1_a, rs2_a, imm_a, a_sel_a, b_sel_a, w_en_a, jump_a, w_sel_a,
                  br_a, func_a, mrd_a, mwr_a, jal_a, jalr_a, ill_a, ebk_a, mdu_a, mop_a};
  assign got_e = {out_pc_e, 1'b0, rd_e, 1'b0, rs1_e, 1'b0, rs2_e, imm_e, a_sel_e, b_sel_e, w_en_e,
                  jump_e, w_sel_e, br_e, func_e, mrd_e, mwr_e, jal_e, jalr_e, ill_e, ebk_e, mdu_e, mop_e};

  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic chk_bnd(input string nm, input bnd_t got, input bnd_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Instruction-level reference: what EXU should see for instruction x at pc with an aw-bit register file.
  function automatic bnd_t ref_decode(input logic [31:0] x, input logic [31:0] pc, input int aw);
    bnd_t       b;
    bit         ok, ur, u1, u2;
    int         lim;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] brmap [8];
    logic [2:0] ldmap [8];
    logic [1:0] stmap [8];
    brmap = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
    ldmap = '{3'd1, 3'd3, 3'd5, 3'd0, 3'd2, 3'd4, 3'd0, 3'd0};
    stmap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    b = '0; ok = 1'b0; ur = 1'b0; u1 = 1'b0; u2 = 1'b0;
    f3 = x[14:12];
    f7 = x[31:25];
    lim = 1 << aw;
    case (x[6:0])
      7'h37: begin ok = 1; ur = 1; b.imm = {x[31:12], 12'h000}; b.w_en = 1; b.w_sel = 2'd2; b.b_sel = 1; b.func = 4'd14; end
      7'h17: begin ok = 1; ur = 1; b.imm = {x[31:12], 12'h000}; b.w_en = 1; b.w_sel = 2'd2; b.b_sel = 1; end
      7'h6f: begin
        ok = 1; ur = 1; b.imm = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
        b.w_en = 1; b.w_sel = 2'd1; b.b_sel = 1; b.jump = 1; b.jal = 1;
      end
      7'h67: begin
        ok = (f3 == 3'd0); ur = 1; u1 = 1; b.imm = 32'($signed(x[31:20]));
        b.w_en = 1; b.w_sel = 2'd1; b.a_sel = 1; b.b_sel = 1; b.jump = 1; b.jalr = 1;
      end
      7'h63: begin
        ok = (brmap[f3] != 3'd0); u1 = 1; u2 = 1; b.br = brmap[f3]; b.b_sel = 1;
        b.imm = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
      end
      7'h03: begin
        ok = (ldmap[f3] != 3'd0); ur = 1; u1 = 1; b.mrd = ldmap[f3]; b.imm = 32'($signed(x[31:20]));
        b.w_en = 1; b.w_sel = 2'd3; b.a_sel = 1; b.b_sel = 1;
      end
      7'h23: begin
        ok = (stmap[f3] != 2'd0); u1 = 1; u2 = 1; b.mwr = stmap[f3];
        b.imm = 32'($signed({x[31:25], x[11:7]})); b.a_sel = 1; b.b_sel = 1;
      end
      7'h13: begin
        ur = 1; u1 = 1; b.imm = 32'($signed(x[31:20])); b.w_en = 1; b.w_sel = 2'd2; b.a_sel = 1; b.b_sel = 1;
        if (f3 == 3'd1) begin ok = (f7 == 7'd0); b.func = 4'd1; end
        else if (f3 == 3'd5) begin ok = (f7 == 7'd0) || (f7 == 7'd32); b.func = (f7 == 7'd32) ? 4'd13 : 4'd5; end
        else begin ok = 1; b.func = 4'(f3); end
      end
      7'h33: begin
        ur = 1; u1 = 1; u2 = 1; b.w_en = 1; b.w_sel = 2'd2; b.a_sel = 1;
        if (f7 == 7'd0) begin ok = 1; b.func = 4'(f3); end
        else if (f7 == 7'd32) begin ok = (f3 == 3'd0) || (f3 == 3'd5); b.func = 4'd8 + 4'(f3); end
        else if (f7 == 7'd1) begin
`ifdef YSYX_23060240_IDU_RV32M_EN
          ok = 1;
`else
          ok = 0;
`endif
          b.mdu = 1; b.mop = f3;
        end
      end
      7'h0f: ok = (f3 == 3'd0);
      7'h73: begin ok = (x == 32'h0010_0073); b.ebk = 1; end
      default: ok = 0;
    endcase
    if ((ur && int'(x[11:7]) >= lim) || (u1 && int'(x[19:15]) >= lim) || (u2 && int'(x[24:20]) >= lim)) ok = 0;
    if (ok) begin
      b.rd  = ur ? x[11:7]  : 5'd0;
      b.rs1 = u1 ? x[19:15] : 5'd0;
      b.rs2 = u2 ? x[24:20] : 5'd0;
    end else begin
      b = '0;
      b.ill = 1;
    end
    b.pc = pc;
    return b;
  endfunction

  // Model FIFO update on the active edge.
  always @(posedge clk) begin
    bit pu, po;
    if (!rst_n) begin
      mq.delete();
    end else begin
      pu = in_valid && (mq.size() < DEPTH);
      po = (mq.size() != 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (po) void'(mq.pop_front());
        if (pu) mq.push_back('{in_inst, in_pc});
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    bnd_t ea, ee;
    bit   v;
    v  = (mq.size() != 0);
    ea = v ? ref_decode(mq[0].inst, mq[0].pc, 5) : '0;
    ee = v ? ref_decode(mq[0].inst, mq[0].pc, 4) : '0;
    chk32("out_valid_rf5", 32'(out_valid_a), 32'(v));
    chk32("out_valid_rf4", 32'(out_valid_e), 32'(v));
    chk32("in_ready_rf5", 32'(in_ready_a), 32'(mq.size() < DEPTH));
    chk32("in_ready_rf4", 32'(in_ready_e), 32'(mq.size() < DEPTH));
    chk_bnd("bundle_rf5", got_a, ea);
    chk_bnd("bundle_rf4", got_e, ee);
  end

  task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] p, input logic r, input logic f);
    #1;
    in_valid = v; in_inst = i; in_pc = p; out_ready = r; flush = f;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    logic [6:0]  ops [11];
    int          k;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
    k = int'($urandom_range(0, 19));
    x = $urandom;
    if (k == 0) return 32'h0010_0073;
    if (k < 4) return x;
    x[6:0] = ops[$urandom_range(0, 10)];
    case ($urandom_range(0, 3))
      0: x[31:25] = 7'h00;
      1: x[31:25] = 7'h20;
      2: x[31:25] = 7'h01;
      default: x[31:25] = x[31:25];
    endcase
    if ($urandom_range(0, 1) == 1) begin
      x[11] = 1'b0; x[19] = 1'b0; x[24] = 1'b0;
    end
    return x;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
    repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk32("reset_in_ready", 32'(in_ready_a), 32'd1);
    chk32("reset_out_valid", 32'(out_valid_a), 32'd0);
    chk32("reset_pc", out_pc_a, 32'd0);
    rst_n = 1'b1;

    // addi x1,x0,5
    cyc(1'b1, 32'h0050_0093, 32'h8000_0000, 1'b0, 1'b0);
    chk32("addi_valid", 32'(out_valid_a), 32'd1);
    chk32("addi_pc", out_pc_a, 32'h8000_0000);
    chk32("addi_rd", 32'(rd_a), 32'd1);
    chk32("addi_rs1", 32'(rs1_a), 32'd0);
    chk32("addi_imm", imm_a, 32'd5);
    chk32("addi_func", 32'(func_a), 32'd0);
    chk32("addi_w_en", 32'(w_en_a), 32'd1);
    chk32("addi_w_sel", 32'(w_sel_a), 32'd2);
    chk32("addi_b_sel", 32'(b_sel_a), 32'd1);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk32("drain_valid", 32'(out_valid_a), 32'd0);

    // three back-to-back with EXU stalled
    cyc(1'b1, 32'h0010_0113, 32'h0000_0100, 1'b0, 1'b0);
    cyc(1'b1, 32'h0020_F463, 32'h0000_0104, 1'b0, 1'b0);
    chk32("full_in_ready", 32'(in_ready_a), 32'd0);
    cyc(1'b1, 32'h0220_81B3, 32'h0000_0108, 1'b0, 1'b0);
    chk32("held_pc", out_pc_a, 32'h0000_0100);
    cyc(1'b1, 32'h0220_81B3, 32'h0000_0108, 1'b1, 1'b0);
    chk32("bgeu_pc", out_pc_a, 32'h0000_0104);
    chk32("bgeu_br", 32'(br_a), 32'd6);
    chk32("bgeu_imm", imm_a, 32'd8);
    chk32("bgeu_w_en", 32'(w_en_a), 32'd0);
    chk32("bgeu_jump", 32'(jump_a), 32'd0);
    chk32("bgeu_illegal", 32'(ill_a), 32'd0);
    cyc(1'b1, 32'h0220_81B3, 32'h0000_0108, 1'b1, 1'b0);
    chk32("mul_pc", out_pc_a, 32'h0000_0108);
`ifdef YSYX_23060240_IDU_RV32M_EN
    chk32("mul_is_mdu", 32'(mdu_a), 32'd1);
    chk32("mul_mdu_op", 32'(mop_a), 32'd0);
    chk32("mul_rd", 32'(rd_a), 32'd3);
    chk32("mul_w_en", 32'(w_en_a), 32'd1);
`else
    chk32("mul_illegal", 32'(ill_a), 32'd1);
    chk32("mul_w_en", 32'(w_en_a), 32'd0);
`endif
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk32("mul_drained", 32'(out_valid_a), 32'd0);

    // flush with a full buffer, then flush beating a push into a non-full one
    cyc(1'b1, 32'h0010_0113, 32'h0000_0200, 1'b0, 1'b0);
    cyc(1'b1, 32'h0020_F463, 32'h0000_0204, 1'b0, 1'b0);
    cyc(1'b1, 32'h0050_0093, 32'h0000_0208, 1'b0, 1'b1);
    chk32("flush_valid", 32'(out_valid_a), 32'd0);
    chk32("flush_in_ready", 32'(in_ready_a), 32'd1);
    chk32("flush_pc", out_pc_a, 32'd0);
    chk32("flush_imm", imm_a, 32'd0);
    cyc(1'b1, 32'h0010_0113, 32'h0000_0300, 1'b0, 1'b0);
    cyc(1'b1, 32'h0050_0093, 32'h0000_0304, 1'b0, 1'b1);
    chk32("flush_vs_push", 32'(out_valid_a), 32'd0);

    // illegal, ebreak, RV32E index limit
    cyc(1'b1, 32'hFFFF_FFFF, 32'h0000_0400, 1'b1, 1'b0);
    chk32("ones_illegal", 32'(ill_a), 32'd1);
    chk32("ones_w_en", 32'(w_en_a), 32'd0);
    chk32("ones_pc", out_pc_a, 32'h0000_0400);
    cyc(1'b1, 32'h0010_0073, 32'h0000_0404, 1'b1, 1'b0);
    chk32("ebreak", 32'(ebk_a), 32'd1);
    chk32("ebreak_illegal", 32'(ill_a), 32'd0);
    cyc(1'b1, 32'h0000_0813, 32'h0000_0408, 1'b1, 1'b0);
    chk32("x16_rf4_illegal", 32'(ill_e), 32'd1);
    chk32("x16_rf5_illegal", 32'(ill_a), 32'd0);
    chk32("x16_rf5_rd", 32'(rd_a), 32'd16);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) < 7, rand_inst(), $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end
    repeat (4) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060240_idu_stage.md
Name: ysyx_23060240_idu_stage

Overview:
Registered, parametrised RV32I/RV32E instruction-decode stage with valid/ready handshakes on both sides. It sits between IFU and EXU and buffers up to DEPTH decoded bundles. Each bundle carries PC, register indices, a sign-extended immediate and the control encodings EXU/LSU/WBU consume. It adds illegal-instruction and ebreak detection, flush, and optional RV32M decode.

Parameters:
- RF_ADDR_W, 5, register-index width; 5 = RV32I, 4 = RV32E.
- DEPTH, 2, bundle buffer entries; legal values 1..4.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all buffered bundles.
- in_valid  in  1  IFU offers inst/pc.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  EXU consumes head.
- out_pc  out  PC_W  PC of the instruction.
- rd, rs1, rs2  out  RF_ADDR_W each  register indices.
- imm  out  32  sign-extended immediate (I/S/B/U/J per type; 0 for R-type).
- alu_a_sel, alu_b_sel, w_en, jump  out  1 each.
- w_sel  out  2  01 = pc+4, 10 = ALU, 11 = load, 00 = none.
- branch_type  out  3  beq 001, bne 010, blt 011, bge 100, bltu 101, bgeu 110, else 000.
- alu_func  out  4  add 0000, sub 1000, sll 0001, srl 0101, sra 1101, slt 0010, sltu 0011, xor 0100, or 0110, and 0111, lui 1110.
- mem_rd_ctrl  out  3  lb 001, lbu 010, lh 011, lhu 100, lw 101.
- mem_wr_ctrl  out  2  sb 01, sh 10, sw 11.
- is_jal, is_jalr, illegal, ebreak  out  1 each.
- is_mdu  out  1  M-extension op (macro only).
- mdu_op  out  3  funct3 of M op (macro only).

Behaviour:
- Clock and reset: single clock domain; rst_n is asynchronous and active-low.
- Reset: count = 0; out_valid = 0; in_ready = 1; all data outputs 0.
- Decode and storage: decode is combinational on in_inst. The decoded bundle is written into a circular buffer (wr_ptr, rd_ptr, count) on push.
- Handshake: push = in_valid & in_ready; pop = out_valid & out_ready. in_ready = (count < DEPTH), registered-state only, with no combinational path from out_ready.
- Full buffer: when full, a same-cycle pop does not permit a push.
- Latency: 1 cycle. A bundle pushed in cycle N is visible with out_valid = 1 in N+1 if the buffer was empty.
- Ordering: strict FIFO order. Bundles are held stable while out_valid & ~out_ready.
- Idle outputs: out_valid = (count != 0). All data outputs are forced to 0 when out_valid = 0.
- Simultaneous push and pop: count unchanged; both pointers advance, wrapping modulo DEPTH.
- Flush: synchronous. Next cycle count = 0 and pointers = 0. Flush has priority over a same-cycle push (input not captured) and over pop.
- Control field semantics:
  - w_en = U | jal | I-type | R-type.
  - alu_a_sel = S | I | R.
  - alu_b_sel = ~R.
  - jump = jal | jalr.
- ebreak: inst == 0x00100073 gives ebreak = 1 with all other control fields 0 and illegal = 0.
- Illegal instructions: any encoding outside RV32I base (plus M with the macro), and anything other than ebreak in the SYSTEM opcode, gives illegal = 1, w_en = 0 and all control fields 0. The bundle still passes through with pc intact.
- Register-index check (RF_ADDR_W < 5): a used rd/rs1/rs2 field with bits [4:RF_ADDR_W] nonzero sets illegal. Output indices are the truncated low bits.

Optional Feature:
- Macro: YSYX_23060240_IDU_RV32M_EN.
- Defined: opcode 0x33 with funct7 0x01 decodes as is_mdu = 1, mdu_op = funct3, w_en = 1, w_sel = 10, alu_a_sel = 1, alu_b_sel = 0, alu_func = 0000.
- Undefined: is_mdu/mdu_op ports still exist and are tied to 0; those encodings set illegal = 1.

Test Plan:
- Reset, then push addi x1,x0,5 (0x00500093) at pc 0x80000000 -> next cycle out_valid=1, out_pc=0x80000000, rd=1, rs1=0, imm=5, alu_func=0000, w_en=1, w_sel=10, alu_b_sel=1.
- out_ready=0, push three instructions back-to-back with DEPTH=2 -> in_ready=0 after the 2nd; third held at input. Raise out_ready -> all three emerge in order, one per cycle.
- Push bgeu x1,x2,+8 (0x0020F463) -> branch_type=110, imm=8, w_en=0, jump=0, illegal=0.
- Two bundles buffered, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, all outputs 0, input not captured.
- Push 0xFFFFFFFF -> illegal=1, w_en=0. Push 0x00100073 -> ebreak=1, illegal=0. With RF_ADDR_W=4, push addi x16,x0,0 (0x00000813) -> illegal=1.
- Push mul x3,x1,x2 (0x022081B3) -> with macro: is_mdu=1, mdu_op=000, rd=3, w_en=1. Without macro: illegal=1, w_en=0.
